// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared divider FSM encoding and default operand width
package calc_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        ITER = 2'b10,
        DONE = 2'b11
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-and-subtract step of the divider
module div_step
    import calc_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   P,
    input  logic [WIDTH-1:0] Qsh,
    input  logic [WIDTH-1:0] y_r,
    output logic [WIDTH:0]   P_next,
    output logic [WIDTH-1:0] Qsh_next
);

    logic [WIDTH:0] p_shift;
    logic [WIDTH:0] trial;

    always_comb begin
        p_shift = {P[WIDTH-1:0], Qsh[WIDTH-1]};
        trial   = p_shift - {1'b0, y_r};
        // A clear guard bit means the divisor fitted: keep the difference.
        if (!trial[WIDTH]) begin
            P_next   = trial;
            Qsh_next = {Qsh[WIDTH-2:0], 1'b1};
        end else begin
            P_next   = p_shift;
            Qsh_next = {Qsh[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider_unit.sv
// rtl/seq_divider_unit.sv - iterative unsigned restoring divider, one quotient bit per clock
module seq_divider_unit
    import calc_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             div_Go,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             div_Done,
    output logic [WIDTH-1:0] Quot,
    output logic [WIDTH-1:0] Rem,
    output logic             div_Err,
    output logic             Busy
);

    div_state_t       state;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH:0]   p_r;
    logic [WIDTH-1:0] q_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] q_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .P        (p_r),
        .Qsh      (q_r),
        .y_r      (y_r),
        .P_next   (p_next),
        .Qsh_next (q_next)
    );

    assign div_Done = (state == DONE);
    assign Busy     = (state != IDLE);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x_r     <= '0;
            y_r     <= '0;
            p_r     <= '0;
            q_r     <= '0;
            cnt     <= '0;
            Quot    <= '0;
            Rem     <= '0;
            div_Err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_Go) begin
                        x_r   <= X;
                        y_r   <= Y;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    p_r <= '0;
                    q_r <= x_r;
                    cnt <= CNT_W'(WIDTH);
                    // Zero divisor skips the iterations and reports the dividend as remainder.
                    if (y_r == '0) begin
                        Quot    <= '0;
                        Rem     <= x_r;
                        div_Err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    p_r <= p_next;
                    q_r <= q_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        Quot    <= q_next;
                        Rem     <= p_next[WIDTH-1:0];
                        div_Err <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_unit.sv
// tb/tb_seq_divider_unit.sv - directed self-checking bench for seq_divider_unit
module tb_seq_divider_unit;

    localparam int W = 4;

    logic         CLK;
    logic         rst_n;
    logic         div_Go;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         div_Done;
    logic [W-1:0] Quot;
    logic [W-1:0] Rem;
    logic         div_Err;
    logic         Busy;

    int n_cmp = 0;
    int n_err = 0;

    seq_divider_unit dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .div_Go   (div_Go),
        .X        (X),
        .Y        (Y),
        .div_Done (div_Done),
        .Quot     (Quot),
        .Rem      (Rem),
        .div_Err  (div_Err),
        .Busy     (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic go(input int x, input int y);
        @(negedge CLK);
        X      = W'(x);
        Y      = W'(y);
        div_Go = 1'b1;
        @(posedge CLK);
        #1 div_Go = 1'b0;
    endtask

    task automatic run_op(input int x, input int y, input string tag);
        int n;
        int eq, er, ee, elat;
        if (y == 0) begin
            eq = 0; er = x; ee = 1; elat = 1;
        end else begin
            eq = x / y; er = x % y; ee = 0; elat = W + 1;
        end
        go(x, y);
        chk({tag, "_busy"}, int'(Busy), 1);
        n = 0;
        while (!div_Done && n < 20) begin
            @(posedge CLK);
            #1 n++;
        end
        chk({tag, "_lat"}, n, elat);
        chk({tag, "_quot"}, int'(Quot), eq);
        chk({tag, "_rem"}, int'(Rem), er);
        chk({tag, "_err"}, int'(div_Err), ee);
        @(posedge CLK);
        #1 chk({tag, "_done_pulse"}, int'(div_Done), 0);
    endtask

    initial begin
        int pulses;
        rst_n  = 1'b0;
        div_Go = 1'b0;
        X      = '0;
        Y      = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(div_Done), 0);
        chk("rst_quot", int'(Quot), 0);
        chk("rst_rem", int'(Rem), 0);
        chk("rst_err", int'(div_Err), 0);
        @(negedge CLK) rst_n = 1'b1;

        run_op(13, 4, "t1_13_4");
        run_op(7, 0, "t2_div0");
        run_op(15, 1, "t3_15_1");
        run_op(3, 7, "t3_3_7");
        run_op(0, 5, "t3_0_5");
        run_op(15, 15, "t3_15_15");

        // Re-issue during ITER must be ignored.
        go(13, 4);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        X = 4'd1; Y = 4'd1; div_Go = 1'b1;
        @(posedge CLK);
        #1 div_Go = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge CLK);
            #1 if (div_Done) pulses++;
        end
        chk("t4_pulses", pulses, 1);
        chk("t4_quot", int'(Quot), 3);
        chk("t4_rem", int'(Rem), 1);

        // Reset in the middle of an operation.
        go(13, 4);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        @(negedge CLK) rst_n = 1'b0;
        #1;
        chk("t5_busy", int'(Busy), 0);
        chk("t5_quot", int'(Quot), 0);
        chk("t5_rem", int'(Rem), 0);
        chk("t5_done", int'(div_Done), 0);
        @(negedge CLK) rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(posedge CLK);
            #1 if (div_Done) pulses++;
        end
        chk("t5_no_done", pulses, 0);
        run_op(9, 2, "t5_9_2");

        for (int xi = 0; xi < 16; xi++)
            for (int yi = 0; yi < 16; yi++)
                run_op(xi, yi, $sformatf("sw_%0d_%0d", xi, yi));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
